// File: rtl/xosera_host_bus_if.sv
// Host request/response and Xosera 8-bit bus signals, bundled for xosera_host_bus.
// Latency: none (wires only).
// Backpressure: req_valid_i/req_ready_o handshake; rsp_valid_o is a one-cycle pulse.
// Ports: req_* host request, rsp_* completion, bus_* byte-wide Xosera bus, intr_* interrupt.
interface xosera_host_bus_if;
    // host request / response
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wr_i;
    logic [3:0]  req_reg_num_i;
    logic [1:0]  req_bytes_i;
    logic [15:0] req_data_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_data_o;
    // Xosera register bus
    logic        bus_cs_n_o;
    logic        bus_rd_nwr_o;
    logic [3:0]  bus_reg_num_o;
    logic        bus_bytesel_o;
    logic [7:0]  bus_data_o;
    logic        bus_data_oe_o;
    logic [7:0]  bus_data_i;
    logic        bus_intr_i;
    // interrupt latch
    logic        intr_clear_i;
    logic        intr_pending_o;

    // slave: the bus initiator block itself
    modport slave (
        input  req_valid_i, req_wr_i, req_reg_num_i, req_bytes_i, req_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o,
        output bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o,
        output bus_data_o, bus_data_oe_o,
        input  bus_data_i, bus_intr_i, intr_clear_i,
        output intr_pending_o
    );

    // master: host plus Xosera side (driver / model)
    modport master (
        output req_valid_i, req_wr_i, req_reg_num_i, req_bytes_i, req_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o,
        input  bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o,
        input  bus_data_o, bus_data_oe_o,
        output bus_data_i, bus_intr_i, intr_clear_i,
        input  intr_pending_o
    );
endinterface

// File: rtl/xosera_host_bus.sv
// Host-side initiator for the Xosera 8-bit register bus: 16-bit requests -> 1 or 2 byte CS cycles.
// Latency: rsp_valid_o at t1+P (one lane) or t1+2P (two lanes), P = SETUP+STROBE+HOLD; t1 for an empty mask.
// Backpressure: req_ready_o only in IDLE; one request in flight, accepted again in the rsp_valid_o cycle.
// Ports: clk, reset_n_i (async active-low), bus = xosera_host_bus_if.slave (request, response, bus, interrupt).
module xosera_host_bus #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic               clk,
    input  logic               reset_n_i,
    xosera_host_bus_if.slave   bus
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        second_q, second_d;     // odd lane still to go after the even one
    logic [7:0]  wlow_q, wlow_d;         // odd write byte, needed only for the second cycle
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_nwr_q, rd_nwr_d;
    logic [3:0]  reg_num_q, reg_num_d;
    logic        bytesel_q, bytesel_d;
    logic [7:0]  dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        intr_s_q, intr_s_d;     // registered bus_intr_i
    logic        intr_s2_q, intr_s2_d;   // previous value, for edge detect
    logic        intr_pend_q, intr_pend_d;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            second_q    <= 1'b0;
            wlow_q      <= 8'd0;
            rsp_data_q  <= 16'd0;
            rsp_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_nwr_q    <= 1'b1;
            reg_num_q   <= 4'd0;
            bytesel_q   <= 1'b0;
            dout_q      <= 8'd0;
            oe_q        <= 1'b0;
            intr_s_q    <= 1'b0;
            intr_s2_q   <= 1'b0;
            intr_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            second_q    <= second_d;
            wlow_q      <= wlow_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cs_n_q      <= cs_n_d;
            rd_nwr_q    <= rd_nwr_d;
            reg_num_q   <= reg_num_d;
            bytesel_q   <= bytesel_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            intr_s_q    <= intr_s_d;
            intr_s2_q   <= intr_s2_d;
            intr_pend_q <= intr_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        second_d    = second_q;
        wlow_d      = wlow_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        cs_n_d      = cs_n_q;
        rd_nwr_d    = rd_nwr_q;
        reg_num_d   = reg_num_q;
        bytesel_d   = bytesel_q;
        dout_d      = dout_q;
        oe_d        = oe_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    rsp_data_d = 16'd0;
                    wr_d       = bus.req_wr_i;
                    wlow_d     = bus.req_data_i[7:0];
                    if (bus.req_bytes_i == 2'b00) begin
                        // nothing to transfer: complete immediately, bus untouched
                        rsp_valid_d = 1'b1;
                    end else begin
                        // bus outputs are registered, so the SETUP values are loaded here
                        second_d  = (bus.req_bytes_i == 2'b11);
                        state_d   = ST_SETUP;
                        cnt_d     = SETUP_LD;
                        reg_num_d = bus.req_reg_num_i;
                        rd_nwr_d  = !bus.req_wr_i;
                        oe_d      = bus.req_wr_i;
                        bytesel_d = !bus.req_bytes_i[1];
                        dout_d    = bus.req_bytes_i[1] ? bus.req_data_i[15:8] : bus.req_data_i[7:0];
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                    cs_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        if (bytesel_q) rsp_data_d[7:0]  = bus.bus_data_i;
                        else           rsp_data_d[15:8] = bus.bus_data_i;
                    end
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    cs_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    if (second_q) begin
                        second_d  = 1'b0;
                        state_d   = ST_SETUP;
                        cnt_d     = SETUP_LD;
                        bytesel_d = 1'b1;
                        dout_d    = wlow_q;
                    end else begin
                        // reg_num/bytesel/data keep their last values while idle
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                        rd_nwr_d    = 1'b1;
                        oe_d        = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Interrupt: one register stage, then rising-edge detect; a set beats a same-cycle clear.
    always_comb begin
        intr_s_d    = bus.bus_intr_i;
        intr_s2_d   = intr_s_q;
        intr_pend_d = intr_pend_q;
        if (intr_s_q && !intr_s2_q) intr_pend_d = 1'b1;
        else if (bus.intr_clear_i)  intr_pend_d = 1'b0;
    end

    assign bus.req_ready_o    = (state_q == ST_IDLE);
    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.rsp_data_o     = rsp_data_q;
    assign bus.bus_cs_n_o     = cs_n_q;
    assign bus.bus_rd_nwr_o   = rd_nwr_q;
    assign bus.bus_reg_num_o  = reg_num_q;
    assign bus.bus_bytesel_o  = bytesel_q;
    assign bus.bus_data_o     = dout_q;
    assign bus.bus_data_oe_o  = oe_q;
    assign bus.intr_pending_o = intr_pend_q;

endmodule

// File: tb/tb_xosera_host_bus.sv
// Bench for xosera_host_bus: directed requests, scoreboarded responses and CS cycles, Xosera read model.
// Latency: checks default timing (CS at t3/t11, rsp at t1/t9/t17).
// Backpressure: driver waits on req_ready_o with a cycle budget.
module tb_xosera_host_bus;

    logic clk;
    logic reset_n;
    int   cyc;
    int   total;
    int   bad;

    xosera_host_bus_if ifc();

    xosera_host_bus #(
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (4),
        .HOLD_CYCLES   (2)
    ) dut (
        .clk       (clk),
        .reset_n_i (reset_n),
        .bus       (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] dat;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [3:0]  rn;
        logic        bsel;
        logic [7:0]  d;
    } bus_t;

    rsp_t       rsp_q[$];
    bus_t       bus_q[$];
    logic [7:0] rd_q[$];
    bus_t       cur;
    logic       prev_cs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: Xosera-side model plus response scoreboard, sampled on the falling edge.
    initial prev_cs = 1'b1;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_cs = 1'b1;
        end else begin
            if (!ifc.bus_cs_n_o && prev_cs) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_cs_fall", 32'(cyc), 32'hFFFF_FFFF);
                    cur = '{cyc: cyc, wr: !ifc.bus_rd_nwr_o, rn: ifc.bus_reg_num_o,
                            bsel: ifc.bus_bytesel_o, d: ifc.bus_data_o};
                end else begin
                    cur = bus_q.pop_front();
                    chk("cs_fall_cycle", 32'(cyc), 32'(cur.cyc));
                end
                if (!cur.wr) ifc.bus_data_i = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hEE;
            end
            // bus outputs must match the expected cycle while CS is low and in the rising cycle
            if (!ifc.bus_cs_n_o || !prev_cs) begin
                chk("bus_rd_nwr", 32'(ifc.bus_rd_nwr_o), 32'(!cur.wr));
                chk("bus_oe", 32'(ifc.bus_data_oe_o), 32'(cur.wr));
                chk("bus_reg_num", 32'(ifc.bus_reg_num_o), 32'(cur.rn));
                chk("bus_bytesel", 32'(ifc.bus_bytesel_o), 32'(cur.bsel));
                if (cur.wr) chk("bus_wdata", 32'(ifc.bus_data_o), 32'(cur.d));
            end
            if (ifc.rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rsp_data", 32'(ifc.rsp_data_o), 32'(e.dat));
                    chk("rsp_ready", 32'(ifc.req_ready_o), 32'd1);
                    chk("idle_bus_state", 32'({ifc.bus_rd_nwr_o, ifc.bus_data_oe_o}), 32'b10);
                end
            end
            prev_cs = ifc.bus_cs_n_o;
        end
    end

    // Issue one request and push its expected bus cycles and response (default timing).
    task automatic send(input logic wr, input logic [3:0] rn, input logic [1:0] m,
                        input logic [15:0] d, input logic [7:0] rb0, input logic [7:0] rb1,
                        input logic [15:0] exp, input bit abort);
        int t0;
        bit ok;
        @(posedge clk);
        #1;
        ifc.req_valid_i   = 1'b1;
        ifc.req_wr_i      = wr;
        ifc.req_reg_num_i = rn;
        ifc.req_bytes_i   = m;
        ifc.req_data_i    = d;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
        end else begin
            t0 = cyc;
            if (m != 2'b00) begin
                bus_q.push_back('{cyc: t0 + 3, wr: wr, rn: rn, bsel: !m[1],
                                  d: (m[1] ? d[15:8] : d[7:0])});
                if (!wr) rd_q.push_back(rb0);
                if (m == 2'b11 && !abort) begin
                    bus_q.push_back('{cyc: t0 + 11, wr: wr, rn: rn, bsel: 1'b1, d: d[7:0]});
                    if (!wr) rd_q.push_back(rb1);
                end
            end
            if (!abort) begin
                if (m == 2'b00)      rsp_q.push_back('{cyc: t0 + 1,  dat: 16'h0000});
                else if (m == 2'b11) rsp_q.push_back('{cyc: t0 + 17, dat: exp});
                else                 rsp_q.push_back('{cyc: t0 + 9,  dat: exp});
            end
        end
        @(posedge clk);
        #1;
        ifc.req_valid_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        total = 0;
        bad   = 0;
        reset_n            = 1'b0;
        ifc.req_valid_i    = 1'b0;
        ifc.req_wr_i       = 1'b0;
        ifc.req_reg_num_i  = 4'd0;
        ifc.req_bytes_i    = 2'b00;
        ifc.req_data_i     = 16'd0;
        ifc.bus_data_i     = 8'd0;
        ifc.bus_intr_i     = 1'b0;
        ifc.intr_clear_i   = 1'b0;

        // reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", 32'(ifc.bus_cs_n_o), 32'd1);
        chk("rst_rd_nwr", 32'(ifc.bus_rd_nwr_o), 32'd1);
        chk("rst_oe", 32'(ifc.bus_data_oe_o), 32'd0);
        chk("rst_bus_misc", 32'({ifc.bus_data_o, ifc.bus_reg_num_o, ifc.bus_bytesel_o}), 32'd0);
        chk("rst_rsp", 32'({ifc.rsp_valid_o, ifc.rsp_data_o}), 32'd0);
        chk("rst_intr", 32'(ifc.intr_pending_o), 32'd0);
        chk("rst_ready", 32'(ifc.req_ready_o), 32'd1);
        #2 reset_n = 1'b1;

        // write reg 3, both lanes: 0xAB even then 0xCD odd
        send(1'b1, 4'd3, 2'b11, 16'hABCD, 8'h00, 8'h00, 16'h0000, 1'b0);
        // read reg 5, both lanes: model returns 0x12 then 0x34 (back-to-back with the write)
        send(1'b0, 4'd5, 2'b11, 16'h0000, 8'h12, 8'h34, 16'h1234, 1'b0);
        // read odd lane only
        send(1'b0, 4'd9, 2'b01, 16'h0000, 8'h5A, 8'h00, 16'h005A, 1'b0);
        // read even lane only
        send(1'b0, 4'd12, 2'b10, 16'h0000, 8'hC3, 8'h00, 16'hC300, 1'b0);
        // write odd lane only
        send(1'b1, 4'd15, 2'b01, 16'h1177, 8'h00, 8'h00, 16'h0000, 1'b0);
        // empty mask: no CS, response next cycle with zero data
        wait_cycles(12);
        send(1'b0, 4'd1, 2'b00, 16'hFFFF, 8'h00, 8'h00, 16'h0000, 1'b0);
        wait_cycles(12);

        // reset during STROBE of a write
        send(1'b1, 4'd2, 2'b10, 16'h7700, 8'h00, 8'h00, 16'h0000, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ifc.bus_cs_n_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_cs_seen", 32'(ok), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(ifc.bus_cs_n_o), 32'd1);
        chk("abort_oe", 32'(ifc.bus_data_oe_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(ifc.req_ready_o), 32'd1);
        wait_cycles(25);

        // interrupt: pulse -> pending two cycles later
        @(posedge clk); #1 ifc.bus_intr_i = 1'b1;
        @(posedge clk); #1 ifc.bus_intr_i = 1'b0;
        @(negedge clk);
        chk("intr_early", 32'(ifc.intr_pending_o), 32'd0);
        @(negedge clk);
        chk("intr_set", 32'(ifc.intr_pending_o), 32'd1);
        // clear alone
        @(posedge clk); #1 ifc.intr_clear_i = 1'b1;
        @(posedge clk); #1 ifc.intr_clear_i = 1'b0;
        @(negedge clk);
        chk("intr_clear", 32'(ifc.intr_pending_o), 32'd0);
        // clear in the same cycle as a new set: set wins
        wait_cycles(2);
        @(posedge clk); #1 ifc.bus_intr_i = 1'b1;
        @(posedge clk); #1 ifc.bus_intr_i = 1'b0; ifc.intr_clear_i = 1'b1;
        @(negedge clk);
        chk("intr_pre_race", 32'(ifc.intr_pending_o), 32'd0);
        @(posedge clk); #1 ifc.intr_clear_i = 1'b0;
        @(negedge clk);
        chk("intr_set_wins", 32'(ifc.intr_pending_o), 32'd1);
        @(posedge clk); #1 ifc.intr_clear_i = 1'b1;
        @(posedge clk); #1 ifc.intr_clear_i = 1'b0;
        @(negedge clk);
        chk("intr_clear2", 32'(ifc.intr_pending_o), 32'd0);

        // drain and confirm every expected event was observed
        for (int i = 0; i < 40; i++) begin
            if (rsp_q.size() == 0 && bus_q.size() == 0) break;
            @(posedge clk);
        end
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
